// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM and one-clock press/release pulses.
// Optional long-press detector enabled by defining the macro LONG_PRESS_EN.
module button_conditioner #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000,
   parameter int          SYNC_STAGES     = 2,
   parameter logic [19:0] LONG_CYCLES     = 20'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic button_raw,
   output logic button_level,
   output logic button_pulse,
   output logic release_pulse,
   output logic long_press
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   state_t      state;
   state_t      state_nx;
   logic [19:0] cnt;
   logic [19:0] cnt_nx;
   logic        level_nx;
   logic        pulse_nx;
   logic        release_nx;

   function automatic logic [19:0] sat_inc(input logic [19:0] value);
      sat_inc = (value == 20'hF_FFFF) ? value : value + 20'd1;
   endfunction

   // Synchroniser stage: only the last flop is seen by the FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce FSM stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         button_level  <= 1'b0;
         button_pulse  <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         button_level  <= level_nx;
         button_pulse  <= pulse_nx;
         release_pulse <= release_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = button_level;
      pulse_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
         IDLE: begin
            if (s) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = 20'd1;
            end else begin
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == DEBOUNCE_CYCLES) begin
               state_nx = HELD;
               cnt_nx   = '0;
               level_nx = 1'b1;
               pulse_nx = 1'b1;
            end else begin
               cnt_nx   = sat_inc(cnt);
            end
         end
         HELD: begin
            if (!s) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = 20'd1;
            end
         end
         RELEASE_WAIT: begin
            // A bounce back to pressed returns to HELD without a new press pulse
            if (s) begin
               state_nx   = HELD;
               cnt_nx     = '0;
            end else if (cnt == DEBOUNCE_CYCLES) begin
               state_nx   = IDLE;
               cnt_nx     = '0;
               level_nx   = 1'b0;
               release_nx = 1'b1;
            end else begin
               cnt_nx     = sat_inc(cnt);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

`ifdef LONG_PRESS_EN
   logic [19:0] hcnt;
   logic [19:0] hcnt_inc;

   assign hcnt_inc = hcnt + 20'd1;

   // Long-press stage: hcnt restarts only when a press is accepted, so release
   // bounces do not re-arm it; it saturates, so long_press fires once per press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hcnt       <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (state == PRESS_WAIT && state_nx == HELD) begin
            hcnt <= '0;
         end else if (state_nx == IDLE) begin
            hcnt <= '0;
         end else if ((state == HELD || state == RELEASE_WAIT) && hcnt < LONG_CYCLES) begin
            hcnt <= hcnt_inc;
            if (hcnt_inc == LONG_CYCLES) begin
               long_press <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_long_cfg;

   assign unused_long_cfg = ^LONG_CYCLES;
   assign long_press      = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scenario bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=8.
module tb_button_conditioner;

   localparam logic [19:0] DEB  = 20'd4;
   localparam int          SYNC = 2;
   localparam logic [19:0] LONG = 20'd8;
`ifdef LONG_PRESS_EN
   localparam bit LONG_ON = 1'b1;
`else
   localparam bit LONG_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   logic button_raw;
   logic button_level;
   logic button_pulse;
   logic release_pulse;
   logic long_press;

   int checks;
   int failures;
   logic [3:0] exp_q[$];

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .SYNC_STAGES    (SYNC),
      .LONG_CYCLES    (LONG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .button_raw   (button_raw),
      .button_level (button_level),
      .button_pulse (button_pulse),
      .release_pulse(release_pulse),
      .long_press   (long_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector order: {level, pulse, release, long}; index i is the sample after edge i.
   task automatic test_reset();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 18; i++) begin
         rst        = (i >= 3);
         button_raw = (i < 10);
         exp_q.push_back({(i >= 9 && i < 16), (i == 9), (i == 16), 1'b0});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_glitch();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 46; i++) begin
         button_raw = (i < 3) || (i >= 13 && i < 17) || (i >= 27 && i < 32);
         exp_q.push_back({(i >= 33 && i < 38), (i == 33), (i == 38), 1'b0});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL glitch[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 40; i++) begin
         button_raw = (i < 20);
         exp_q.push_back({(i >= 6 && i < 26), (i == 6), (i == 26), (LONG_ON && i == 14)});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL clean_press[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_release_bounce();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 50; i++) begin
         button_raw = (i < 10) || (i >= 12 && i < 14) || (i >= 16 && i < 18) || (i >= 20 && i < 40);
         exp_q.push_back({(i >= 6 && i < 46), (i == 6), (i == 46), (LONG_ON && i == 14)});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL release_bounce[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid_debounce();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 22; i++) begin
         rst        = !(i == 4 || i == 5);
         button_raw = (i < 14);
         exp_q.push_back({(i >= 12 && i < 20), (i == 12), (i == 20), 1'b0});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_mid_debounce[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_long_press();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 40; i++) begin
         button_raw = (i < 30);
         exp_q.push_back({(i >= 6 && i < 36), (i == 6), (i == 36), (LONG_ON && i == 14)});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL long_press[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int i = 0; i < 30; i++) begin
         button_raw = (i < 7) || (i >= 14 && i < 21);
         exp_q.push_back({((i >= 6 && i < 13) || (i >= 20 && i < 27)),
                          (i == 6 || i == 20), (i == 13 || i == 27), 1'b0});
         @(posedge clk); #1;
         obs = {button_level, button_pulse, release_pulse, long_press};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL back_to_back[%0d] got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b0;
      button_raw = 1'b0;
      test_reset();
      test_glitch();
      test_clean_press();
      test_release_bounce();
      test_reset_mid_debounce();
      test_long_press();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
